// File: rtl/tqvp_mux_display_scanner_if.sv
// ============================================================================
//  Module      : tqvp_mux_display_scanner_if
//  Description : TinyQV peripheral register bus seen by the display scanner.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tqvp_mux_display_scanner_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

`default_nettype wire

// File: rtl/tqvp_mux_display_scanner.sv
// ============================================================================
//  Module      : tqvp_mux_display_scanner
//  Description : Time-multiplexed multi-digit 7-segment scanner with double
//                buffered digits, leading-zero suppression and PWM brightness.
//                Optional macro TQVP_SCAN_FRAME_IRQ_EN adds the frame pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tqvp_mux_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE_W = 8
) (
    input  wire                       clk,
    input  wire                       rst_n,
    tqvp_mux_display_scanner_if.slave bus,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_out,
    output logic                      frame_irq
);

    localparam int              c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [5:0]      c_CTRL_RST = 6'h32;

    logic [5:0]            r_shadow [NUM_DIGITS];
    logic [5:0]            r_active [NUM_DIGITS];
    logic [5:0]            r_ctrl;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_count;
    logic [3:0]            r_bright;
    logic [3:0]            r_phase;
    logic [c_IDX_W-1:0]    r_index;

    logic w_en, w_sal, w_lzs, w_lt, w_dal, w_cim;
    logic w_wr_digit, w_wr_ctrl, w_wr_presc, w_wr_bright;
    logic w_tick, w_commit, w_lit, w_blank, w_upper_zero, w_frame_flag;
    logic [5:0]            w_cur;
    logic [7:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_dig;
    logic                  w_unused_bits;

    assign {w_cim, w_dal, w_lt, w_lzs, w_sal, w_en} = r_ctrl;
    assign w_unused_bits = ^bus.data_in[7:6];

    assign w_wr_digit  = bus.data_write && (32'(bus.address) < NUM_DIGITS);
    assign w_wr_ctrl   = bus.data_write && (bus.address == 4'hC);
    assign w_wr_presc  = bus.data_write && (bus.address == 4'hD);
    assign w_wr_bright = bus.data_write && (bus.address == 4'hE);

    assign w_tick   = w_en && (r_count == r_presc);
    assign w_commit = w_tick && (r_phase == 4'hF) && (r_index == c_LAST);

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= 6'h00;
            r_ctrl   <= c_CTRL_RST;
            r_presc  <= PRESCALE_W'(32'hFF);
            r_bright <= 4'hF;
        end else begin
            if (w_wr_digit)  r_shadow[bus.address[c_IDX_W-1:0]] <= bus.data_in[5:0];
            if (w_wr_ctrl)   r_ctrl   <= bus.data_in[5:0];
            if (w_wr_presc)  r_presc  <= PRESCALE_W'(bus.data_in);
            if (w_wr_bright) r_bright <= bus.data_in[3:0];
        end
    end

    // Scan engine: prescaler -> 16-step PWM phase -> digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_phase <= 4'h0;
            r_index <= '0;
        end else if (!w_en) begin
            r_count <= '0;
            r_phase <= 4'h0;
            r_index <= '0;
        end else begin
            if (w_wr_presc || w_tick) r_count <= '0;
            else                      r_count <= r_count + 1'b1;
            if (w_tick) begin
                r_phase <= r_phase + 4'h1;
                if (r_phase == 4'hF)
                    r_index <= (r_index == c_LAST) ? '0 : r_index + 1'b1;
            end
        end
    end

    // Active copy samples the pre-write shadow, so a write landing on the
    // commit edge waits for the following commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_active[i] <= 6'h00;
        end else if (!w_en || w_cim || w_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_active[i] <= r_shadow[i];
        end
    end

    always_comb begin
        w_cur        = r_active[r_index];
        w_upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((c_IDX_W'(j) >= r_index) && (r_active[j][4:0] != 5'd0))
                w_upper_zero = 1'b0;
        end
        w_blank = w_cur[5] || (w_lzs && (r_index != '0) && w_upper_zero);
        w_lit   = w_en && (r_phase <= r_bright);
        if (!w_lit)       w_seg = 8'h00;
        else if (w_lt)    w_seg = 8'hFF;
        else if (w_blank) w_seg = 8'h00;
        else              w_seg = {w_cur[4], hex_font(w_cur[3:0])};
        w_dig = '0;
        if (w_lit) w_dig[r_index] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= 8'hFF;
            dig_out <= '1;
        end else begin
            seg_out <= w_seg ^ {8{w_sal}};
            dig_out <= w_dig ^ {NUM_DIGITS{w_dal}};
        end
    end

`ifdef TQVP_SCAN_FRAME_IRQ_EN
    logic r_frame_irq;
    logic r_frame_flag;

    // Set has priority over a clear-by-write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_irq  <= 1'b0;
            r_frame_flag <= 1'b0;
        end else begin
            r_frame_irq <= w_commit;
            if (w_commit)
                r_frame_flag <= 1'b1;
            else if (bus.data_write && (bus.address == 4'hF))
                r_frame_flag <= 1'b0;
        end
    end

    assign frame_irq    = r_frame_irq;
    assign w_frame_flag = r_frame_flag;
`else
    assign frame_irq    = 1'b0;
    assign w_frame_flag = 1'b0;
`endif

    always_comb begin
        bus.data_out = 8'h00;
        if (32'(bus.address) < NUM_DIGITS) begin
            bus.data_out = {2'b00, r_shadow[bus.address[c_IDX_W-1:0]]};
        end else begin
            case (bus.address)
                4'hC:    bus.data_out = {2'b00, r_ctrl};
                4'hD:    bus.data_out = 8'(r_presc);
                4'hE:    bus.data_out = {4'h0, r_bright};
                4'hF:    bus.data_out = {w_frame_flag, 4'h0, 3'(r_index)};
                default: bus.data_out = 8'h00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tqvp_mux_display_scanner.sv
// ============================================================================
//  Module      : tb_tqvp_mux_display_scanner
//  Description : Directed self-checking bench for the 4-digit display scanner.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tqvp_mux_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] seg_out;
    logic [3:0] dig_out;
    logic       frame_irq;

    int checks = 0;
    int errors = 0;

    logic [3:0] obs_dig [256];
    logic [7:0] obs_seg [256];
    logic [7:0] hex_exp [4];

    tqvp_mux_display_scanner_if bus_if ();

    tqvp_mux_display_scanner #(.NUM_DIGITS(4), .PRESCALE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .seg_out   (seg_out),
        .dig_out   (dig_out),
        .frame_irq (frame_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.data_in    = d;
        bus_if.data_write = 1'b1;
        @(negedge clk);
        bus_if.data_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus_if.address = a;
        #1;
        d = bus_if.data_out;
    endtask

    task automatic wait_dig(input logic [3:0] pat, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dig_out == pat) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // The current sample is element 0; n-1 further clocks are recorded.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            obs_dig[i] = dig_out;
            obs_seg[i] = seg_out;
        end
    endtask

    task automatic load_digits(input logic [7:0] d0, d1, d2, d3);
        bus_write(4'h0, d0);
        bus_write(4'h1, d1);
        bus_write(4'h2, d2);
        bus_write(4'h3, d3);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        #2 rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (seg_out !== 8'hFF || dig_out !== 4'hF || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: seg=%h dig=%b irq=%b, want FF 1111 0", seg_out, dig_out, frame_irq);
        end
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 8'h32) begin errors++; $display("FAIL reset_ctrl: got %h want 32", rd); end
        bus_read(4'hD, rd);
        checks++;
        if (rd !== 8'hFF) begin errors++; $display("FAIL reset_presc: got %h want FF", rd); end
        bus_read(4'hE, rd);
        checks++;
        if (rd !== 8'h0F) begin errors++; $display("FAIL reset_bright: got %h want 0F", rd); end
        bus_read(4'hF, rd);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", rd); end
        bus_read(4'h2, rd);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL reset_digit2: got %h want 00", rd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_registers();
        logic [7:0] rd;
        bus_write(4'h1, 8'hFF);
        bus_read(4'h1, rd);
        checks++;
        if (rd !== 8'h3F) begin errors++; $display("FAIL digit_rw: got %h want 3F", rd); end
        bus_write(4'h5, 8'hAA);
        bus_read(4'h5, rd);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL digit_oob: got %h want 00", rd); end
        bus_write(4'hC, 8'hFE);
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 8'h3E) begin errors++; $display("FAIL ctrl_rw: got %h want 3E", rd); end
        bus_write(4'hE, 8'hA7);
        bus_read(4'hE, rd);
        checks++;
        if (rd !== 8'h07) begin errors++; $display("FAIL bright_rw: got %h want 07", rd); end
        bus_write(4'hD, 8'h5A);
        bus_read(4'hD, rd);
        checks++;
        if (rd !== 8'h5A) begin errors++; $display("FAIL presc_rw: got %h want 5A", rd); end
        bus_write(4'hC, 8'h00);
    endtask

    task automatic test_hex_scan();
        bit ok;
        logic [3:0] ed;
        load_digits(8'h01, 8'h02, 8'h03, 8'h1F);
        bus_write(4'hD, 8'h00);
        bus_write(4'hE, 8'h0F);
        bus_write(4'hC, 8'h01);
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hex_sync: dig=%b never reached 0001", dig_out); return; end
        capture(64);
        for (int i = 0; i < 64; i++) begin
            ed = 4'b0001 << (i / 16);
            checks++;
            if (obs_dig[i] !== ed || obs_seg[i] !== hex_exp[i / 16]) begin
                errors++;
                $display("FAIL hex_scan[%0d]: dig=%b seg=%h want %b %h", i, obs_dig[i], obs_seg[i], ed, hex_exp[i / 16]);
            end
        end
    endtask

    task automatic test_lzs();
        bit ok;
        logic [3:0] ed;
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a = '{8'h3F, 8'h00, 8'h00, 8'h00};
        exp_b = '{8'h3F, 8'h3F, 8'hBF, 8'h00};
        bus_write(4'hC, 8'h00);
        load_digits(8'h00, 8'h00, 8'h00, 8'h00);
        bus_write(4'hC, 8'h05);
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lzs_sync: dig=%b never reached 0001", dig_out); return; end
        capture(64);
        for (int i = 0; i < 64; i++) begin
            ed = 4'b0001 << (i / 16);
            checks++;
            if (obs_dig[i] !== ed || obs_seg[i] !== exp_a[i / 16]) begin
                errors++;
                $display("FAIL lzs_zero[%0d]: dig=%b seg=%h want %b %h", i, obs_dig[i], obs_seg[i], ed, exp_a[i / 16]);
            end
        end
        bus_write(4'hC, 8'h00);
        bus_write(4'h2, 8'h10);
        bus_write(4'hC, 8'h05);
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lzs_sync2: dig=%b never reached 0001", dig_out); return; end
        capture(64);
        for (int i = 0; i < 64; i++) begin
            ed = 4'b0001 << (i / 16);
            checks++;
            if (obs_dig[i] !== ed || obs_seg[i] !== exp_b[i / 16]) begin
                errors++;
                $display("FAIL lzs_dp[%0d]: dig=%b seg=%h want %b %h", i, obs_dig[i], obs_seg[i], ed, exp_b[i / 16]);
            end
        end
    endtask

    task automatic test_brightness();
        bit ok;
        logic [3:0] ed;
        logic [7:0] es;
        bus_write(4'hC, 8'h00);
        load_digits(8'h01, 8'h02, 8'h03, 8'h1F);
        bus_write(4'hD, 8'h03);
        bus_write(4'hE, 8'h04);
        bus_write(4'hC, 8'h01);
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bright_sync: dig=%b never reached 0001", dig_out); return; end
        capture(256);
        for (int i = 0; i < 256; i++) begin
            ed = ((i % 64) < 20) ? (4'b0001 << (i / 64)) : 4'b0000;
            es = ((i % 64) < 20) ? hex_exp[i / 64] : 8'h00;
            checks++;
            if (obs_dig[i] !== ed || obs_seg[i] !== es) begin
                errors++;
                $display("FAIL bright[%0d]: dig=%b seg=%h want %b %h", i, obs_dig[i], obs_seg[i], ed, es);
            end
        end
    endtask

    task automatic test_double_buffer();
        bit ok;
        logic [7:0] rd;
        bus_write(4'hC, 8'h00);
        load_digits(8'h01, 8'h02, 8'h03, 8'h1F);
        bus_write(4'hD, 8'h00);
        bus_write(4'hE, 8'h0F);
        bus_write(4'hC, 8'h01);
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dbuf_sync: dig=%b never reached 0001", dig_out); return; end
        bus_write(4'h0, 8'h08);
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (dig_out !== 4'b0001 || seg_out !== 8'h06) begin
                errors++;
                $display("FAIL dbuf_hold[%0d]: dig=%b seg=%h want 0001 06", i, dig_out, seg_out);
            end
        end
        tick();
        checks++;
        if (dig_out !== 4'b0010 || seg_out !== 8'h5B) begin
            errors++;
            $display("FAIL dbuf_next: dig=%b seg=%h want 0010 5B", dig_out, seg_out);
        end
        bus_read(4'hF, rd);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("FAIL status_index: got %h want 01", rd); end
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok || seg_out !== 8'h7F) begin
            errors++;
            $display("FAIL dbuf_commit: ok=%b seg=%h want 1 7F", ok, seg_out);
        end
        bus_write(4'hC, 8'h21);
        wait_dig(4'b0010, ok);
        wait_dig(4'b0001, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cim_sync: dig=%b never reached 0001", dig_out); return; end
        bus_write(4'h0, 8'h0A);
        tick();
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (dig_out !== 4'b0001 || seg_out !== 8'h77) begin
                errors++;
                $display("FAIL cim_immediate[%0d]: dig=%b seg=%h want 0001 77", i, dig_out, seg_out);
            end
        end
    endtask

    task automatic test_frame_irq();
        bit ok;
        int gap;
        logic [7:0] rd;
        bus_write(4'hD, 8'h00);
        bus_write(4'hC, 8'h01);
`ifdef TQVP_SCAN_FRAME_IRQ_EN
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin tick(); ok = frame_irq; end
        checks++;
        if (!ok) begin errors++; $display("FAIL irq_first: frame_irq=%b never pulsed", frame_irq); return; end
        gap = 0;
        ok  = 1'b0;
        for (int i = 1; i < 100 && !ok; i++) begin
            tick();
            if (frame_irq) begin ok = 1'b1; gap = i; end
        end
        checks++;
        if (gap !== 64) begin errors++; $display("FAIL irq_period: got %0d want 64", gap); end
        bus_read(4'hF, rd);
        checks++;
        if (rd[7] !== 1'b1) begin errors++; $display("FAIL status_set: got %b want 1", rd[7]); end
        tick();
        checks++;
        if (frame_irq !== 1'b0) begin errors++; $display("FAIL irq_width: got %b want 0", frame_irq); end
        bus_write(4'hF, 8'h00);
        bus_read(4'hF, rd);
        checks++;
        if (rd[7] !== 1'b0) begin errors++; $display("FAIL status_clear: got %b want 0", rd[7]); end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = frame_irq; end
        for (int i = 0; i < 63; i++) tick();
        bus_write(4'hF, 8'h00);
        bus_read(4'hF, rd);
        checks++;
        if (rd[7] !== 1'b1 || frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL status_set_wins: flag=%b irq=%b want 1 1", rd[7], frame_irq);
        end
`else
        ok = 1'b0;
        for (int i = 0; i < 130; i++) begin tick(); if (frame_irq !== 1'b0) ok = 1'b1; end
        checks++;
        if (ok) begin errors++; $display("FAIL irq_tied: frame_irq went high, want 0"); end
        bus_read(4'hF, rd);
        checks++;
        if (rd[7] !== 1'b0) begin errors++; $display("FAIL status_flag: got %b want 0", rd[7]); end
`endif
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] rd;
        bus_write(4'hD, 8'h00);
        bus_write(4'hC, 8'h01);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg_out !== 8'hFF || dig_out !== 4'hF) begin
            errors++;
            $display("FAIL reset_async: seg=%h dig=%b want FF 1111", seg_out, dig_out);
        end
        bus_read(4'hC, rd);
        checks++;
        if (rd !== 8'h32) begin errors++; $display("FAIL reset_mid_ctrl: got %h want 32", rd); end
        bus_read(4'hE, rd);
        checks++;
        if (rd !== 8'h0F) begin errors++; $display("FAIL reset_mid_bright: got %h want 0F", rd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        hex_exp = '{8'h06, 8'h5B, 8'h4F, 8'hF1};
        bus_if.address    = 4'h0;
        bus_if.data_in    = 8'h00;
        bus_if.data_write = 1'b0;
        test_reset();
        test_registers();
        test_hex_scan();
        test_lzs();
        test_brightness();
        test_double_buffer();
        test_frame_irq();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
